// File: rtl/bridge_arbiter_pkg.sv
// bridge_arbiter_pkg
// Shared definitions for the processor-side bridge arbiter: the FSM state
// encodings (also exported on the debug 'owner' port), the default burst
// limit, and a saturating increment used by the beat counter.
package bridge_arbiter_pkg;

   // Debug port values follow the enum encoding directly.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2,
      ARB_TURN = 2'd3
   } arbState_e;

   localparam int ARB_MAX_BURST_DEFAULT = 8;

   // Counts up to 'limit' and then holds.
   function automatic logic [7:0] satInc8(input logic [7:0] cnt, input logic [7:0] limit);
      satInc8 = (cnt < limit) ? cnt + 8'd1 : cnt;
   endfunction

endpackage

// File: rtl/arb_mux.sv
// arb_mux
// Combinational 2:1 selector that drives the bridge's address, write-data
// and byte-enable inputs from the granted master. When neither grant is
// active every output is zero, so the bridge never sees a stray write.
// Ports:
//   gnt0, gnt1              grants from the arbiter FSM (mutually exclusive)
//   addr0/wd0/byteEn0       master 0 beat
//   addr1/wd1/byteEn1       master 1 beat
//   prAddr/prWd/prByteEn    selected beat towards the bridge
module arb_mux
   import bridge_arbiter_pkg::*;
(
   input  logic        gnt0,
   input  logic        gnt1,
   input  logic [31:0] addr0,
   input  logic [31:0] wd0,
   input  logic [3:0]  byteEn0,
   input  logic [31:0] addr1,
   input  logic [31:0] wd1,
   input  logic [3:0]  byteEn1,
   output logic [31:0] prAddr,
   output logic [31:0] prWd,
   output logic [3:0]  prByteEn
);

   // Zero unless a grant is active; gnt0 takes precedence only as a
   // tie-break, the FSM never raises both.
   always_comb begin
      prAddr   = '0;
      prWd     = '0;
      prByteEn = '0;
      if (gnt0) begin
         prAddr   = addr0;
         prWd     = wd0;
         prByteEn = byteEn0;
      end else if (gnt1) begin
         prAddr   = addr1;
         prWd     = wd1;
         prByteEn = byteEn1;
      end
   end

endmodule

// File: rtl/bridge_arbiter.sv
// bridge_arbiter
// Shares the single processor-side bridge port between master 0 (CPU data
// access) and master 1 (secondary bus master). Round-robin between the two
// with a bounded burst length; a granted beat completes in the same cycle.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   mX_req/addr/wd/byteen   master X beat request (byteen 0 = read)
//   mX_gnt                  beat completes when mX_req & mX_gnt
//   mX_rd                   bridge read data, valid for the granted master
//   PrAddr/PrWD/PrByteEn    towards the bridge, zero when nothing granted
//   PrRD                    read data from the bridge
//   owner                   debug view of the FSM state
module bridge_arbiter
   import bridge_arbiter_pkg::*;
#(
   parameter int MAX_BURST = ARB_MAX_BURST_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wd,
   input  logic [3:0]  m0_byteen,
   output logic        m0_gnt,
   output logic [31:0] m0_rd,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wd,
   input  logic [3:0]  m1_byteen,
   output logic        m1_gnt,
   output logic [31:0] m1_rd,
   output logic [31:0] PrAddr,
   output logic [31:0] PrWD,
   output logic [3:0]  PrByteEn,
   input  logic [31:0] PrRD,
   output logic [1:0]  owner
);

   localparam logic [7:0] maxBurst8 = 8'(MAX_BURST);

   arbState_e  state;
   arbState_e  stateNext;
   logic [7:0] beatCnt;
   logic [7:0] beatCntNext;
   logic       last;
   logic       lastNext;
   logic       nextOwner;
   logic       nextOwnerNext;
   logic       burstDone;

   // The beat in flight is the last one allowed while the other master
   // waits. Using >= rather than == means an owner that already ran past
   // the limit alone still yields as soon as the other master shows up.
   assign burstDone = ({1'b0, beatCnt} + 9'd1) >= {1'b0, maxBurst8};

   // State register; reset returns to IDLE with master 1 marked as the
   // last owner so master 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         beatCnt   <= '0;
         last      <= 1'b1;
         nextOwner <= 1'b0;
      end else begin
         state     <= stateNext;
         beatCnt   <= beatCntNext;
         last      <= lastNext;
         nextOwner <= nextOwnerNext;
      end
   end

   // Next-state and grant logic. Grants depend only on the state and the
   // owner's own request, never on the bridge read data.
   always_comb begin
      stateNext     = state;
      beatCntNext   = beatCnt;
      lastNext      = last;
      nextOwnerNext = nextOwner;
      m0_gnt        = 1'b0;
      m1_gnt        = 1'b0;
      case (state)
         ARB_IDLE: begin
            beatCntNext = '0;
            if (m0_req && m1_req) begin
               stateNext = last ? ARB_OWN0 : ARB_OWN1;
            end else if (m0_req) begin
               stateNext = ARB_OWN0;
            end else if (m1_req) begin
               stateNext = ARB_OWN1;
            end
         end
         ARB_OWN0: begin
            m0_gnt = m0_req;
            if (!m0_req) begin
               lastNext      = 1'b0;
               nextOwnerNext = 1'b1;
               stateNext     = m1_req ? ARB_TURN : ARB_IDLE;
            end else begin
               beatCntNext = satInc8(beatCnt, maxBurst8);
               if (m1_req && burstDone) begin
                  lastNext      = 1'b0;
                  nextOwnerNext = 1'b1;
                  stateNext     = ARB_TURN;
               end
            end
         end
         ARB_OWN1: begin
            m1_gnt = m1_req;
            if (!m1_req) begin
               lastNext      = 1'b1;
               nextOwnerNext = 1'b0;
               stateNext     = m0_req ? ARB_TURN : ARB_IDLE;
            end else begin
               beatCntNext = satInc8(beatCnt, maxBurst8);
               if (m0_req && burstDone) begin
                  lastNext      = 1'b1;
                  nextOwnerNext = 1'b0;
                  stateNext     = ARB_TURN;
               end
            end
         end
         ARB_TURN: begin
            // Dead cycle; the incoming owner may have given up meanwhile.
            beatCntNext = '0;
            if (nextOwner) begin
               stateNext = m1_req ? ARB_OWN1 : ARB_IDLE;
            end else begin
               stateNext = m0_req ? ARB_OWN0 : ARB_IDLE;
            end
         end
         default: begin
            stateNext = ARB_IDLE;
         end
      endcase
   end

   arb_mux uMux (
      .gnt0     (m0_gnt),
      .gnt1     (m1_gnt),
      .addr0    (m0_addr),
      .wd0      (m0_wd),
      .byteEn0  (m0_byteen),
      .addr1    (m1_addr),
      .wd1      (m1_wd),
      .byteEn1  (m1_byteen),
      .prAddr   (PrAddr),
      .prWd     (PrWD),
      .prByteEn (PrByteEn)
   );

   assign m0_rd = PrRD;
   assign m1_rd = PrRD;
   assign owner = state;

endmodule
